// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types and the default bundle geometry used by the core stages.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } stage_state_e;

    localparam int CORE_LANES = 2;
    localparam int CORE_WIDTH = 32;

endpackage

// File: rtl/pipe_slot.sv
// One LANES x WIDTH bundle register with clear and load.
// Lanes whose valid bit is low are stored as zero.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int LANES = CORE_LANES,
    parameter int WIDTH = CORE_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   load,
    input  logic [LANES-1:0]       in_valid,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic [LANES-1:0]       valid,
    output logic [LANES*WIDTH-1:0] data
);

    logic [LANES*WIDTH-1:0] masked;

    // NOTE: give every combinational output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        masked = '0;
        for (int l = 0; l < LANES; l++) begin
            if (in_valid[l]) begin
                masked[l*WIDTH +: WIDTH] = in_data[l*WIDTH +: WIDTH];
            end
        end
    end

    // NOTE: the slot is a handful of flops rather than a RAM, so it is cleared on reset; use <= for all state.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= in_valid;
            data  <= masked;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Multi-lane ready/valid pipeline stage with flush and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a skid slot and take in_ready from a register.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = CORE_WIDTH,
    parameter int LANES = CORE_LANES,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [LANES-1:0]       in_valid,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   in_ready,
    output logic [LANES-1:0]       out_valid,
    output logic [LANES*WIDTH-1:0] out_data,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       stall_cnt
);

    stage_state_e           state;
    logic                   in_fire;
    logic                   out_fire;
    logic                   accept;
    logic                   head_load;
    logic                   head_clear;
    logic [LANES-1:0]       head_src_valid;
    logic [LANES*WIDTH-1:0] head_src_data;

    assign in_fire  = (|in_valid) && in_ready;
    assign out_fire = (|out_valid) && out_ready;
    // A bundle offered during flush is dropped even when in_ready is high.
    assign accept   = in_fire && !flush;

`ifdef PIPE_STAGE_SKID_EN
    logic                   in_ready_q;
    logic                   skid_load;
    logic                   skid_clear;
    logic [LANES-1:0]       skid_valid;
    logic [LANES*WIDTH-1:0] skid_data;

    assign in_ready = in_ready_q;

    always_comb begin
        head_load      = 1'b0;
        head_clear     = flush;
        skid_load      = 1'b0;
        skid_clear     = flush;
        head_src_valid = in_valid;
        head_src_data  = in_data;
        if (!flush) begin
            case (state)
                EMPTY: head_load = accept;
                FULL: begin
                    if (accept && out_fire) begin
                        head_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        head_clear = 1'b1;
                    end
                end
                SKID: begin
                    if (out_ready) begin
                        head_load      = 1'b1;
                        skid_clear     = 1'b1;
                        head_src_valid = skid_valid;
                        head_src_data  = skid_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            case (state)
                EMPTY: if (accept) state <= FULL;
                FULL: begin
                    if (accept && !out_ready) begin
                        state      <= SKID;
                        in_ready_q <= 1'b0;
                    end else if (!accept && out_fire) begin
                        state <= EMPTY;
                    end
                end
                SKID: begin
                    if (out_ready) begin
                        state      <= FULL;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    pipe_slot #(
        .LANES (LANES),
        .WIDTH (WIDTH)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .clear    (skid_clear),
        .load     (skid_load),
        .in_valid (in_valid),
        .in_data  (in_data),
        .valid    (skid_valid),
        .data     (skid_data)
    );
`else
    // Combinational out_ready -> in_ready: a full head can be replaced while it drains.
    assign in_ready       = (state != FULL) || out_ready;
    assign head_load      = accept;
    assign head_clear     = flush || (out_fire && !accept);
    assign head_src_valid = in_valid;
    assign head_src_data  = in_data;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state <= EMPTY;
        end else if (accept) begin
            state <= FULL;
        end else if (out_fire) begin
            state <= EMPTY;
        end
    end
`endif

    pipe_slot #(
        .LANES (LANES),
        .WIDTH (WIDTH)
    ) u_head (
        .clk      (clk),
        .reset    (reset),
        .clear    (head_clear),
        .load     (head_load),
        .in_valid (head_src_valid),
        .in_data  (head_src_data),
        .valid    (out_valid),
        .data     (out_data)
    );

    // Flush deliberately leaves the counter alone; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if ((|out_valid) && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; expectations follow PIPE_STAGE_SKID_EN when defined.
module tb_pipe_stage_reg;

    localparam int WIDTH = 32;
    localparam int LANES = 2;
    localparam int CNT_W = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   flush;
    logic [LANES-1:0]       in_valid;
    logic [LANES*WIDTH-1:0] in_data;
    logic                   in_ready;
    logic [LANES-1:0]       out_valid;
    logic [LANES*WIDTH-1:0] out_data;
    logic                   out_ready;
    logic [CNT_W-1:0]       stall_cnt;

    int total  = 0;
    int passed = 0;

    pipe_stage_reg #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
        total++; if (out_valid !== 2'b00) $display("FAIL reset_valid got=%b exp=00", out_valid); else passed++;
        total++; if (out_data !== 64'h0) $display("FAIL reset_data got=%h exp=0", out_data); else passed++;
        total++; if (stall_cnt !== 4'd0) $display("FAIL reset_stall got=%0d exp=0", stall_cnt); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", in_ready); else passed++;
    endtask

    task automatic test_streaming();
        logic [63:0] vec [3];
        vec[0] = {32'h22, 32'h11};
        vec[1] = {32'h44, 32'h33};
        vec[2] = {32'h66, 32'h55};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 2'b11; in_data = vec[i];
            tick();
            total++; if (out_valid !== 2'b11) $display("FAIL stream_valid%0d got=%b exp=11", i, out_valid); else passed++;
            total++; if (out_data !== vec[i]) $display("FAIL stream_data%0d got=%h exp=%h", i, out_data, vec[i]); else passed++;
            total++; if (in_ready !== 1'b1) $display("FAIL stream_ready%0d got=%b exp=1", i, in_ready); else passed++;
        end
        in_valid = 2'b00; in_data = '0;
        tick();
        total++; if (out_valid !== 2'b00) $display("FAIL stream_drain got=%b exp=00", out_valid); else passed++;
        total++; if (stall_cnt !== 4'd0) $display("FAIL stream_stall got=%0d exp=0", stall_cnt); else passed++;
    endtask

    task automatic test_partial_lane();
        out_ready = 1'b1;
        in_valid = 2'b01; in_data = {32'hBBBB, 32'hAAAA};
        tick();
        in_valid = 2'b00; in_data = '0;
        total++; if (out_valid !== 2'b01) $display("FAIL partial_valid got=%b exp=01", out_valid); else passed++;
        total++; if (out_data !== {32'h0, 32'hAAAA}) $display("FAIL partial_data got=%h exp=%h", out_data, {32'h0, 32'hAAAA}); else passed++;
        tick();
        total++; if (out_data !== 64'h0) $display("FAIL partial_drain got=%h exp=0", out_data); else passed++;
    endtask

    task automatic test_backpressure();
        logic [63:0] a_data;
        logic [63:0] b_data;
        a_data = {32'h102, 32'h101};
        b_data = {32'h202, 32'h201};
        out_ready = 1'b0;
        in_valid = 2'b11; in_data = a_data;
        tick();
`ifdef PIPE_STAGE_SKID_EN
        total++; if (in_ready !== 1'b1) $display("FAIL bp_fill_ready got=%b exp=1", in_ready); else passed++;
`else
        total++; if (in_ready !== 1'b0) $display("FAIL bp_fill_ready got=%b exp=0", in_ready); else passed++;
`endif
        in_data = b_data;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (in_ready !== 1'b0) $display("FAIL bp_ready%0d got=%b exp=0", i, in_ready); else passed++;
        end
        total++; if (out_data !== a_data) $display("FAIL bp_head got=%h exp=%h", out_data, a_data); else passed++;
        total++; if (stall_cnt !== 4'd5) $display("FAIL bp_stall got=%0d exp=5", stall_cnt); else passed++;
        out_ready = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
        in_valid = 2'b00;
`endif
        tick();
        in_valid = 2'b00; in_data = '0;
        total++; if (out_valid !== 2'b11) $display("FAIL bp_rel_valid got=%b exp=11", out_valid); else passed++;
        total++; if (out_data !== b_data) $display("FAIL bp_rel_data got=%h exp=%h", out_data, b_data); else passed++;
        total++; if (stall_cnt !== 4'd5) $display("FAIL bp_rel_stall got=%0d exp=5", stall_cnt); else passed++;
        tick();
        total++; if (out_valid !== 2'b00) $display("FAIL bp_drain got=%b exp=00", out_valid); else passed++;
    endtask

    task automatic test_flush();
        logic [CNT_W-1:0] exp_cnt;
        out_ready = 1'b0;
        in_valid = 2'b11; in_data = {32'h302, 32'h301};
        tick();
`ifdef PIPE_STAGE_SKID_EN
        in_data = {32'h312, 32'h311};
        tick();
        exp_cnt = 4'd6;
`else
        exp_cnt = 4'd5;
`endif
        flush = 1'b1; out_ready = 1'b1;
        in_valid = 2'b11; in_data = {32'h402, 32'h401};
        tick();
        flush = 1'b0; in_valid = 2'b00; in_data = '0;
        total++; if (out_valid !== 2'b00) $display("FAIL flush_valid got=%b exp=00", out_valid); else passed++;
        total++; if (out_data !== 64'h0) $display("FAIL flush_data got=%h exp=0", out_data); else passed++;
        total++; if (stall_cnt !== exp_cnt) $display("FAIL flush_stall got=%0d exp=%0d", stall_cnt, exp_cnt); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL flush_ready got=%b exp=1", in_ready); else passed++;
        tick();
        total++; if (out_valid !== 2'b00) $display("FAIL flush_dropped got=%b exp=00", out_valid); else passed++;
    endtask

    task automatic test_saturation_and_reset();
        logic [63:0] g_data;
        g_data = {32'h702, 32'h701};
        out_ready = 1'b0;
        in_valid = 2'b11; in_data = {32'h602, 32'h601};
        tick();
        in_valid = 2'b00; in_data = '0;
        for (int i = 0; i < 20; i++) tick();
        total++; if (stall_cnt !== 4'd15) $display("FAIL sat_stall got=%0d exp=15", stall_cnt); else passed++;
        total++; if (out_valid !== 2'b11) $display("FAIL sat_head got=%b exp=11", out_valid); else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (out_valid !== 2'b00) $display("FAIL midrst_valid got=%b exp=00", out_valid); else passed++;
        total++; if (out_data !== 64'h0) $display("FAIL midrst_data got=%h exp=0", out_data); else passed++;
        total++; if (stall_cnt !== 4'd0) $display("FAIL midrst_stall got=%0d exp=0", stall_cnt); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL midrst_ready got=%b exp=1", in_ready); else passed++;
        in_valid = 2'b11; in_data = g_data;
        tick();
        in_valid = 2'b00; in_data = '0;
        total++; if (out_valid !== 2'b11) $display("FAIL postrst_valid got=%b exp=11", out_valid); else passed++;
        total++; if (out_data !== g_data) $display("FAIL postrst_data got=%h exp=%h", out_data, g_data); else passed++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_streaming();
        test_partial_lane();
        test_backpressure();
        test_flush();
        test_saturation_and_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
